id_ex_operand_reg: RTL and testbench
====================================

Name: id_ex_operand_reg

Overview:
- ID/EX pipeline register for the static pipeline CPU, directly downstream of the immediate extender.
- Captures the extender's four 32-bit outputs, the register-file read data, the PC+4 and destination info each cycle.
- Selects the one immediate the EX stage uses, registers it, and precomputes the branch target PC+4+(sign-extended imm<<2).
- Supports stall (hold) and flush (bubble insert) from the hazard unit.

Parameters:
- WIDTH, 32, datapath width for immediates, register data and PC.
- REG_AW, 5, register address width.

Ports:
- clk  input  1  pipeline clock, all state updates on rising edge.
- rst  input  1  asynchronous active-high reset.
- stall  input  1  hold all registered contents this cycle.
- flush  input  1  load a bubble this cycle.
- id_valid  input  1  ID stage holds a real instruction.
- zext5_in  input  WIDTH  zero-extended shamt from extender.
- zext16_in  input  WIDTH  zero-extended imm16.
- sext16_in  input  WIDTH  sign-extended imm16.
- sext18_in  input  WIDTH  sign-extended imm16<<2.
- imm_sel  input  2  immediate select: 0=zext5, 1=zext16, 2=sext16, 3=lui form {imm16,16'b0} taken from zext16_in[15:0].
- pc_plus4_in  input  WIDTH  PC+4 of the ID instruction.
- rs_data_in  input  WIDTH  register file port A.
- rt_data_in  input  WIDTH  register file port B.
- dst_in  input  REG_AW  destination register number.
- reg_we_in  input  1  writeback enable.
- ex_valid  output  1  EX stage holds a real instruction.
- ex_imm  output  WIDTH  selected immediate.
- ex_branch_target  output  WIDTH  pc_plus4 + sext18.
- ex_pc_plus4  output  WIDTH  registered PC+4.
- ex_rs_data  output  WIDTH  registered rs data.
- ex_rt_data  output  WIDTH  registered rt data.
- ex_dst  output  REG_AW  registered destination.
- ex_reg_we  output  1  registered write enable, forced 0 for bubbles.

Behaviour:
- Reset is asynchronous and active-high. While rst=1, every output is 0, including ex_valid and ex_reg_we; the effect is immediate, not at the next edge.
- Latency: one cycle. Inputs sampled at edge N appear on outputs after edge N and stay until the next update.
- Priority per edge: rst > flush > stall > normal load.
- Flush:
  - ex_valid and ex_reg_we go to 0.
  - ex_dst goes to 0.
  - Data fields (imm, target, pc, rs, rt) go to 0, so bubbles are deterministic.
  - Flush wins over a simultaneous stall.
- Stall (flush=0): all outputs hold their prior values exactly, including ex_valid.
- Normal load:
  - ex_valid = id_valid.
  - ex_reg_we = reg_we_in & id_valid.
  - All other fields load from their inputs.
  - ex_imm is selected by imm_sel.
- Immediate select:
  - imm_sel=3 produces {zext16_in[15:0], 16'b0}.
  - An undefined imm_sel value cannot occur (2 bits fully decoded).
- Branch target:
  - Computed combinationally from pc_plus4_in + sext18_in, then registered with the other fields.
  - Addition is modulo 2^WIDTH; carry out is discarded, so wrap-around is silent (e.g. 0xFFFFFFFC + 8 = 0x00000004).
- Invalid instructions: id_valid=0 with no flush still loads data fields, but forces ex_valid=0 and ex_reg_we=0.
- Reset deasserted mid-stall: the first edge with rst=0 obeys stall/flush normally; the held values are the reset zeros.
- No combinational path from any input to any output.

Test Plan:
- Reset: assert rst asynchronously between edges with the registers loaded → all outputs 0 immediately; after release with stall=1 the outputs stay 0.
- Immediate select: imm16=0x8004, shamt=3 (zext5=0x3, zext16=0x00008004, sext16=0xFFFF8004), imm_sel 0..3 on successive cycles → ex_imm = 0x00000003, 0x00008004, 0xFFFF8004, 0x80040000, each one cycle after its input.
- Branch target: pc_plus4=0x00400010, sext18=0xFFFFFFF0 → ex_branch_target=0x00400000. Wrap case: pc_plus4=0xFFFFFFFC, sext18=0x00000008 → 0x00000004.
- Stall: load rs=0x11111111, then hold stall=1 for 3 cycles while inputs change to 0x22222222 → ex_rs_data stays 0x11111111 for all 3 cycles and shows 0x22222222 one cycle after stall drops.
- Flush over stall: flush=1 and stall=1 on the same edge with valid inputs (reg_we=1, dst=5) → ex_valid=0, ex_reg_we=0, ex_dst=0, data fields 0.
- Invalid fetch: id_valid=0, reg_we_in=1, dst=7 → ex_valid=0, ex_reg_we=0, ex_dst=7.

Source files
------------

// File: rtl/id_ex_operand_reg.sv
// ID/EX operand register. It captures the immediate-extender outputs, the
// register-file read data, PC+4 and the destination info. It selects the
// immediate that EX uses and precomputes the branch target. Stall holds all
// contents and flush loads a zeroed bubble.
module id_ex_operand_reg #(
  parameter int WIDTH  = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic              id_valid,
  input  logic [WIDTH-1:0]  zext5_in,
  input  logic [WIDTH-1:0]  zext16_in,
  input  logic [WIDTH-1:0]  sext16_in,
  input  logic [WIDTH-1:0]  sext18_in,
  input  logic [1:0]        imm_sel,
  input  logic [WIDTH-1:0]  pc_plus4_in,
  input  logic [WIDTH-1:0]  rs_data_in,
  input  logic [WIDTH-1:0]  rt_data_in,
  input  logic [REG_AW-1:0] dst_in,
  input  logic              reg_we_in,
  output logic              ex_valid,
  output logic [WIDTH-1:0]  ex_imm,
  output logic [WIDTH-1:0]  ex_branch_target,
  output logic [WIDTH-1:0]  ex_pc_plus4,
  output logic [WIDTH-1:0]  ex_rs_data,
  output logic [WIDTH-1:0]  ex_rt_data,
  output logic [REG_AW-1:0] ex_dst,
  output logic              ex_reg_we
);

  logic              valid_q,  valid_d;
  logic              reg_we_q, reg_we_d;
  logic [REG_AW-1:0] dst_q,    dst_d;
  logic [WIDTH-1:0]  imm_q,    imm_d;
  logic [WIDTH-1:0]  target_q, target_d;
  logic [WIDTH-1:0]  pc4_q,    pc4_d;
  logic [WIDTH-1:0]  rs_q,     rs_d;
  logic [WIDTH-1:0]  rt_q,     rt_d;

  logic [WIDTH-1:0]  imm_mux;
  logic [WIDTH-1:0]  lui_imm;
  logic [WIDTH-1:0]  target_sum;

  // The LUI form is taken from the low half of the zero-extended imm16.
  // The adder wraps modulo 2^WIDTH and drops the carry.
  always_comb begin
    lui_imm    = WIDTH'(zext16_in[15:0]) << 16;
    target_sum = pc_plus4_in + sext18_in;
    imm_mux    = zext5_in;
    unique case (imm_sel)
      2'd0:    imm_mux = zext5_in;
      2'd1:    imm_mux = zext16_in;
      2'd2:    imm_mux = sext16_in;
      default: imm_mux = lui_imm;
    endcase
  end

  // Next-state selection, in priority order: flush, then stall, then load.
  always_comb begin
    valid_d  = valid_q;
    reg_we_d = reg_we_q;
    dst_d    = dst_q;
    imm_d    = imm_q;
    target_d = target_q;
    pc4_d    = pc4_q;
    rs_d     = rs_q;
    rt_d     = rt_q;
    if (flush) begin
      valid_d  = 1'b0;
      reg_we_d = 1'b0;
      dst_d    = '0;
      imm_d    = '0;
      target_d = '0;
      pc4_d    = '0;
      rs_d     = '0;
      rt_d     = '0;
    end else if (!stall) begin
      valid_d  = id_valid;
      reg_we_d = reg_we_in & id_valid;
      dst_d    = dst_in;
      imm_d    = imm_mux;
      target_d = target_sum;
      pc4_d    = pc_plus4_in;
      rs_d     = rs_data_in;
      rt_d     = rt_data_in;
    end
  end

  // Pipeline register. Reset clears it immediately, without waiting for an edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q  <= 1'b0;
      reg_we_q <= 1'b0;
      dst_q    <= '0;
      imm_q    <= '0;
      target_q <= '0;
      pc4_q    <= '0;
      rs_q     <= '0;
      rt_q     <= '0;
    end else begin
      valid_q  <= valid_d;
      reg_we_q <= reg_we_d;
      dst_q    <= dst_d;
      imm_q    <= imm_d;
      target_q <= target_d;
      pc4_q    <= pc4_d;
      rs_q     <= rs_d;
      rt_q     <= rt_d;
    end
  end

  assign ex_valid         = valid_q;
  assign ex_reg_we        = reg_we_q;
  assign ex_dst           = dst_q;
  assign ex_imm           = imm_q;
  assign ex_branch_target = target_q;
  assign ex_pc_plus4      = pc4_q;
  assign ex_rs_data       = rs_q;
  assign ex_rt_data       = rt_q;

endmodule

// File: tb/tb_id_ex_operand_reg.sv
// Directed testbench for id_ex_operand_reg.
module tb_id_ex_operand_reg;
  localparam int W = 32;
  localparam int A = 5;

  logic         clk, rst, stall, flush, id_valid, reg_we_in;
  logic [W-1:0] zext5_in, zext16_in, sext16_in, sext18_in;
  logic [W-1:0] pc_plus4_in, rs_data_in, rt_data_in;
  logic [1:0]   imm_sel;
  logic [A-1:0] dst_in;
  logic         ex_valid, ex_reg_we;
  logic [W-1:0] ex_imm, ex_branch_target, ex_pc_plus4, ex_rs_data, ex_rt_data;
  logic [A-1:0] ex_dst;

  int n_checks = 0;
  int n_fail   = 0;

  id_ex_operand_reg #(.WIDTH(W), .REG_AW(A)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .id_valid(id_valid),
    .zext5_in(zext5_in), .zext16_in(zext16_in), .sext16_in(sext16_in),
    .sext18_in(sext18_in), .imm_sel(imm_sel), .pc_plus4_in(pc_plus4_in),
    .rs_data_in(rs_data_in), .rt_data_in(rt_data_in), .dst_in(dst_in),
    .reg_we_in(reg_we_in), .ex_valid(ex_valid), .ex_imm(ex_imm),
    .ex_branch_target(ex_branch_target), .ex_pc_plus4(ex_pc_plus4),
    .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data), .ex_dst(ex_dst),
    .ex_reg_we(ex_reg_we)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Order: valid, reg_we, dst, imm, target, pc4, rs, rt.
  wire [2+A+5*W-1:0] out_vec = {ex_valid, ex_reg_we, ex_dst, ex_imm,
                                ex_branch_target, ex_pc_plus4, ex_rs_data, ex_rt_data};

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_zero;
    stall = 0; flush = 0; id_valid = 0; reg_we_in = 0;
    zext5_in = '0; zext16_in = '0; sext16_in = '0; sext18_in = '0;
    pc_plus4_in = '0; rs_data_in = '0; rt_data_in = '0; imm_sel = 2'd0; dst_in = '0;
  endtask

  task automatic test_reset;
    drive_zero();
    rst = 1'b0;
    #1 rst = 1'b1;
    #1;
    n_checks++;
    if (out_vec !== '0) begin
      n_fail++; $display("FAIL reset_initial: got %h want 0", out_vec);
    end
    rst = 1'b0;
    tick();
    id_valid = 1; reg_we_in = 1; dst_in = 5'd9; imm_sel = 2'd1;
    zext16_in = 32'h0000_1234; pc_plus4_in = 32'h0000_0100; sext18_in = 32'h0000_0010;
    rs_data_in = 32'hA5A5_A5A5; rt_data_in = 32'h5A5A_5A5A;
    tick();
    n_checks++;
    if (out_vec !== {1'b1, 1'b1, 5'd9, 32'h0000_1234, 32'h0000_0110, 32'h0000_0100,
                     32'hA5A5_A5A5, 32'h5A5A_5A5A}) begin
      n_fail++; $display("FAIL reset_preload: got %h", out_vec);
    end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (out_vec !== '0) begin
      n_fail++; $display("FAIL reset_async: got %h want 0", out_vec);
    end
    stall = 1;
    #1 rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_checks++;
      if (out_vec !== '0) begin
        n_fail++; $display("FAIL reset_stall_hold%0d: got %h want 0", i, out_vec);
      end
    end
    drive_zero();
  endtask

  task automatic test_imm_sel;
    logic [W-1:0] exp_imm [4];
    exp_imm[0] = 32'h0000_0003; exp_imm[1] = 32'h0000_8004;
    exp_imm[2] = 32'hFFFF_8004; exp_imm[3] = 32'h8004_0000;
    drive_zero();
    id_valid = 1;
    zext5_in = 32'h3; zext16_in = 32'h0000_8004; sext16_in = 32'hFFFF_8004;
    sext18_in = 32'hFFFE_0010;
    for (int i = 0; i < 4; i++) begin
      imm_sel = 2'(i);
      tick();
      n_checks++;
      if (ex_imm !== exp_imm[i]) begin
        n_fail++; $display("FAIL imm_sel%0d: got %h want %h", i, ex_imm, exp_imm[i]);
      end
    end
  endtask

  task automatic test_branch_target;
    drive_zero();
    id_valid = 1;
    pc_plus4_in = 32'h0040_0010; sext18_in = 32'hFFFF_FFF0;
    tick();
    n_checks++;
    if (ex_branch_target !== 32'h0040_0000 || ex_pc_plus4 !== 32'h0040_0010) begin
      n_fail++; $display("FAIL branch_back: got tgt %h pc4 %h want 00400000 00400010",
                         ex_branch_target, ex_pc_plus4);
    end
    pc_plus4_in = 32'hFFFF_FFFC; sext18_in = 32'h0000_0008;
    tick();
    n_checks++;
    if (ex_branch_target !== 32'h0000_0004) begin
      n_fail++; $display("FAIL branch_wrap: got %h want 00000004", ex_branch_target);
    end
  endtask

  task automatic test_stall;
    drive_zero();
    id_valid = 1; reg_we_in = 1; dst_in = 5'd3; rs_data_in = 32'h1111_1111;
    tick();
    stall = 1;
    id_valid = 0; reg_we_in = 0; dst_in = 5'd12;
    rs_data_in = 32'h2222_2222; rt_data_in = 32'h3333_3333;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (ex_rs_data !== 32'h1111_1111 || ex_valid !== 1'b1 || ex_reg_we !== 1'b1 ||
          ex_dst !== 5'd3 || ex_rt_data !== 32'h0) begin
        n_fail++; $display("FAIL stall_hold%0d: got rs %h v %b we %b dst %0d rt %h",
                           i, ex_rs_data, ex_valid, ex_reg_we, ex_dst, ex_rt_data);
      end
    end
    stall = 0;
    tick();
    n_checks++;
    if (ex_rs_data !== 32'h2222_2222 || ex_rt_data !== 32'h3333_3333 || ex_valid !== 1'b0) begin
      n_fail++; $display("FAIL stall_release: got rs %h rt %h v %b want 22222222 33333333 0",
                         ex_rs_data, ex_rt_data, ex_valid);
    end
  endtask

  task automatic test_flush_over_stall;
    drive_zero();
    id_valid = 1; reg_we_in = 1; dst_in = 5'd5; imm_sel = 2'd2;
    sext16_in = 32'hFFFF_ABCD; sext18_in = 32'h0000_0020; pc_plus4_in = 32'h0000_1000;
    rs_data_in = 32'hCAFE_0001; rt_data_in = 32'hCAFE_0002;
    tick();
    flush = 1; stall = 1;
    tick();
    n_checks++;
    if (out_vec !== '0) begin
      n_fail++; $display("FAIL flush_over_stall: got %h want 0", out_vec);
    end
    flush = 0; stall = 0;
    tick();
    n_checks++;
    if (out_vec !== {1'b1, 1'b1, 5'd5, 32'hFFFF_ABCD, 32'h0000_1020, 32'h0000_1000,
                     32'hCAFE_0001, 32'hCAFE_0002}) begin
      n_fail++; $display("FAIL flush_reload: got %h", out_vec);
    end
  endtask

  task automatic test_invalid;
    drive_zero();
    id_valid = 0; reg_we_in = 1; dst_in = 5'd7; rs_data_in = 32'hDEAD_BEEF;
    tick();
    n_checks++;
    if (ex_valid !== 1'b0 || ex_reg_we !== 1'b0 || ex_dst !== 5'd7 ||
        ex_rs_data !== 32'hDEAD_BEEF) begin
      n_fail++; $display("FAIL invalid_fetch: got v %b we %b dst %0d rs %h want 0 0 7 deadbeef",
                         ex_valid, ex_reg_we, ex_dst, ex_rs_data);
    end
  endtask

  task automatic test_back_to_back;
    logic [W-1:0] rs_v [3];
    logic [A-1:0] dst_v [3];
    logic         we_v [3];
    rs_v[0] = 32'h0102_0304; rs_v[1] = 32'hF0E0_D0C0; rs_v[2] = 32'h0000_0001;
    dst_v[0] = 5'd1; dst_v[1] = 5'd31; dst_v[2] = 5'd16;
    we_v[0] = 1'b1; we_v[1] = 1'b0; we_v[2] = 1'b1;
    drive_zero();
    id_valid = 1;
    for (int i = 0; i < 3; i++) begin
      rs_data_in = rs_v[i]; rt_data_in = ~rs_v[i]; dst_in = dst_v[i]; reg_we_in = we_v[i];
      tick();
      n_checks++;
      if (ex_rs_data !== rs_v[i] || ex_rt_data !== ~rs_v[i] || ex_dst !== dst_v[i] ||
          ex_reg_we !== we_v[i] || ex_valid !== 1'b1) begin
        n_fail++; $display("FAIL back_to_back%0d: got rs %h rt %h dst %0d we %b v %b",
                           i, ex_rs_data, ex_rt_data, ex_dst, ex_reg_we, ex_valid);
      end
    end
  endtask

  initial begin
    test_reset();
    test_imm_sel();
    test_branch_target();
    test_stall();
    test_flush_over_stall();
    test_invalid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
